// File: rtl/conv_row_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_row_engine
// Description : Direct valid-mode (stride 1, no padding) convolution of one
//               IMG_H x IMG_W x CH image with one K x K x CH kernel. OW signed
//               MAC lanes compute one output row per pass; results stream out
//               over a valid/ready port. Optional ReLU at the output when
//               CONV_RELU_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_row_engine #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 48,
  parameter int IMG_H  = 4,
  parameter int IMG_W  = 4,
  parameter int CH     = 3,
  parameter int K      = 3,
  parameter int AW     = ((IMG_H*IMG_W*CH) > (K*K*CH))
                         ? (((IMG_H*IMG_W*CH) > 1) ? $clog2(IMG_H*IMG_W*CH) : 1)
                         : (((K*K*CH) > 1) ? $clog2(K*K*CH) : 1),
  parameter int RW     = ((IMG_H-K+1) > 1) ? $clog2(IMG_H-K+1) : 1,
  parameter int CW     = ((IMG_W-K+1) > 1) ? $clog2(IMG_W-K+1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic                     i_wr_sel,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic signed [DATA_W-1:0] i_wr_data,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [ACC_W-1:0]  o_out_data,
  output logic [RW-1:0]            o_out_row,
  output logic [CW-1:0]            o_out_col,
  output logic                     o_out_last
);

  localparam int c_OH    = IMG_H - K + 1;
  localparam int c_OW    = IMG_W - K + 1;
  localparam int c_T     = K * K * CH;
  localparam int c_IMG_N = IMG_H * IMG_W * CH;
  localparam int c_IIW   = (c_IMG_N > 1) ? $clog2(c_IMG_N) : 1;
  localparam int c_FIW   = (c_T > 1) ? $clog2(c_T) : 1;
  localparam int c_KW    = (K > 1) ? $clog2(K) : 1;
  localparam int c_CHW   = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [RW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic [c_KW-1:0]           r_kr;
  logic [c_KW-1:0]           r_kc;
  logic [c_CHW-1:0]          r_ch;
  logic [c_FIW-1:0]          r_t;
  logic                      r_done;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic signed [ACC_W-1:0]   r_out_data;

  logic signed [DATA_W-1:0]  r_img [c_IMG_N];
  logic signed [DATA_W-1:0]  r_flt [c_T];
  logic signed [ACC_W-1:0]   r_acc [c_OW];
  logic signed [ACC_W-1:0]   w_sum [c_OW];

  logic [CW-1:0]             w_col_nx;
  logic                      w_last_row;

  assign w_col_nx   = r_col + CW'(1);
  assign w_last_row = (r_row == RW'(c_OH - 1));

  // Optional rectification, applied only where a result leaves the engine.
  function automatic logic signed [ACC_W-1:0] f_out(input logic signed [ACC_W-1:0] a);
`ifdef CONV_RELU_EN
    f_out = a[ACC_W-1] ? '0 : a;
`else
    f_out = a;
`endif
  endfunction

  // One MAC lane per output column; all lanes share the current kernel tap.
  for (genvar j = 0; j < c_OW; j++) begin : g_lane
    logic [c_IIW-1:0]          w_ia;
    logic signed [2*DATA_W-1:0] w_prod;
    assign w_ia = c_IIW'(((int'(r_row) + int'(r_kr)) * IMG_W + j + int'(r_kc)) * CH
                         + int'(r_ch));
    assign w_prod = (2*DATA_W)'(r_img[w_ia]) * (2*DATA_W)'(r_flt[r_t]);
    assign w_sum[j] = r_acc[j] + ACC_W'(w_prod);
  end

  // Operand memories: loaded only while idle, out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (i_wr_en && (r_state == S_IDLE)) begin
      if (!i_wr_sel && (int'(i_wr_addr) < c_IMG_N)) begin
        r_img[i_wr_addr[c_IIW-1:0]] <= i_wr_data;
      end
      if (i_wr_sel && (int'(i_wr_addr) < c_T)) begin
        r_flt[i_wr_addr[c_FIW-1:0]] <= i_wr_data;
      end
    end
  end

  // Control FSM: per output row, T accumulate cycles then OW streamed beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_ch        <= '0;
      r_t         <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      for (int j = 0; j < c_OW; j++) r_acc[j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ACC;
            r_row   <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_ch    <= '0;
            r_t     <= '0;
            for (int j = 0; j < c_OW; j++) r_acc[j] <= '0;
          end
        end
        S_ACC: begin
          for (int j = 0; j < c_OW; j++) r_acc[j] <= w_sum[j];
          r_t <= r_t + c_FIW'(1);
          // Tap order: channel fastest, then kernel column, then kernel row.
          if (r_ch == c_CHW'(CH - 1)) begin
            r_ch <= '0;
            if (r_kc == c_KW'(K - 1)) begin
              r_kc <= '0;
              r_kr <= r_kr + c_KW'(1);
            end else begin
              r_kc <= r_kc + c_KW'(1);
            end
          end else begin
            r_ch <= r_ch + c_CHW'(1);
          end
          if (r_t == c_FIW'(c_T - 1)) begin
            // Final tap: present lane 0 using the sum that includes this tap.
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_col       <= '0;
            r_out_data  <= f_out(w_sum[0]);
            r_out_last  <= w_last_row && (c_OW == 1);
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            if (r_col == CW'(c_OW - 1)) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              if (w_last_row) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_ACC;
                r_row   <= r_row + RW'(1);
                r_kr    <= '0;
                r_kc    <= '0;
                r_ch    <= '0;
                r_t     <= '0;
                for (int j = 0; j < c_OW; j++) r_acc[j] <= '0;
              end
            end else begin
              r_col      <= w_col_nx;
              r_out_data <= f_out(r_acc[w_col_nx]);
              r_out_last <= w_last_row && (w_col_nx == CW'(c_OW - 1));
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_row   = r_row;
  assign o_out_col   = r_col;
  assign o_out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_row_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_row_engine
// Description : Self-checking bench for conv_row_engine (default parameters).
//               Table of runs with hand-computed results, plus hand-written
//               sequences for start/write during ACC and reset mid-output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_row_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic        i_wr_sel = 1'b0;
  logic [5:0]  i_wr_addr = '0;
  logic [17:0] i_wr_data = '0;
  logic        i_start = 1'b0;
  logic        i_out_ready = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_out_valid;
  logic [47:0] o_out_data;
  logic        o_out_row;
  logic        o_out_col;
  logic        o_out_last;

  int n_checks = 0;
  int n_fail   = 0;

  conv_row_engine dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (i_wr_en),
    .i_wr_sel    (i_wr_sel),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_row   (o_out_row),
    .o_out_col   (o_out_col),
    .o_out_last  (o_out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    int             im;      // 0: all 1, 1: all -1, 2: r*4+c
    int             fm;      // 0: 26-n, 1: all 1, 2: only addr 12 = 1
    int             rmode;   // 0: ready always, 1: ready 1-0-0-1
    bit             inject;  // start + filter write during ACC
    bit             reload;
    logic [3:0][47:0] ed;
  } run_t;

  run_t tbl [5];

  int          nb;
  int          first_valid;
  logic [47:0] b_data [8];
  logic        b_row  [8];
  logic        b_col  [8];
  logic        b_last [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input int val);
    i_wr_en   = 1'b1;
    i_wr_sel  = sel;
    i_wr_addr = 6'(addr);
    i_wr_data = 18'(val);
    @(negedge clk);
    i_wr_en   = 1'b0;
  endtask

  task automatic load(input int im, input int fm);
    for (int a = 0; a < 48; a++) begin
      int v;
      v = (im == 0) ? 1 : (im == 1) ? -1 : (a / 3);
      wr(1'b0, a, v);
    end
    for (int a = 0; a < 27; a++) begin
      int v;
      v = (fm == 0) ? (26 - a) : (fm == 1) ? 1 : ((a == 12) ? 1 : 0);
      wr(1'b1, a, v);
    end
    // Out-of-range writes; filter addr 32 would alias tap 0 if not dropped.
    wr(1'b1, 32, 1000);
    wr(1'b0, 48, 1000);
    wr(1'b0, 63, 1000);
  endtask

  task automatic run_conv(input string nm, input int rmode, input bit inject);
    logic [3:0]  rp;
    int          cyc;
    bit          stall, done_seen, last_hs, busy_bad, early_done, stall_bad;
    logic [47:0] sd;
    logic        sc, sr;
    rp = 4'b1001;
    nb = 0; first_valid = -1;
    stall = 0; done_seen = 0; last_hs = 0; busy_bad = 0; early_done = 0; stall_bad = 0;
    sd = '0; sc = 1'b0; sr = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < 400) begin
      if (last_hs) begin
        check({nm, " done pulse"}, 64'(o_done), 64'd1);
        check({nm, " busy low at done"}, 64'(o_busy), 64'd0);
        done_seen = 1;
      end else begin
        if (o_done) early_done = 1;
        if (!o_busy) busy_bad = 1;
        if (o_out_valid && first_valid < 0) first_valid = cyc;
        if (stall) begin
          if (!o_out_valid || o_out_data !== sd || o_out_col !== sc || o_out_row !== sr)
            stall_bad = 1;
        end
        if (inject && cyc == 5) begin
          i_start = 1'b1; i_wr_en = 1'b1; i_wr_sel = 1'b1; i_wr_addr = '0; i_wr_data = 18'd99;
        end else begin
          i_start = 1'b0; i_wr_en = 1'b0;
        end
        i_out_ready = (rmode == 0) ? 1'b1 : rp[2'(cyc % 4)];
        stall = o_out_valid && !i_out_ready;
        sd = o_out_data; sc = o_out_col; sr = o_out_row;
        if (o_out_valid && i_out_ready) begin
          if (nb < 8) begin
            b_data[nb] = o_out_data; b_row[nb] = o_out_row;
            b_col[nb] = o_out_col;   b_last[nb] = o_out_last;
          end
          nb++;
          if (o_out_last) last_hs = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    i_out_ready = 1'b0;
    check({nm, " done within budget"}, 64'(done_seen), 64'd1);
    check({nm, " first valid latency"}, 64'(first_valid), 64'd27);
    check({nm, " busy held until done"}, 64'(busy_bad), 64'd0);
    check({nm, " no early done"}, 64'(early_done), 64'd0);
    check({nm, " beat count"}, 64'(nb), 64'd4);
    if (rmode == 1) check({nm, " stall hold"}, 64'(stall_bad), 64'd0);
    @(negedge clk);
    check({nm, " done single cycle"}, 64'(o_done), 64'd0);
  endtask

  task automatic check_beats(input string nm, input logic [3:0][47:0] ed);
    for (int k = 0; k < 4 && k < nb; k++) begin
      check($sformatf("%s beat%0d row", nm, k), 64'(b_row[k]), 64'(k / 2));
      check($sformatf("%s beat%0d col", nm, k), 64'(b_col[k]), 64'(k % 2));
      check($sformatf("%s beat%0d last", nm, k), 64'(b_last[k]), 64'(k == 3));
      check($sformatf("%s beat%0d data", nm, k), 64'(b_data[k]), 64'(ed[k]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] neg27;
    bit          flag;
    int          w;
    neg27 = 48'(-27);

    tbl[0] = '{name: "T1", im: 0, fm: 0, rmode: 0, inject: 0, reload: 1,
               ed: {48'd351, 48'd351, 48'd351, 48'd351}};
    tbl[1] = '{name: "T2", im: 0, fm: 0, rmode: 1, inject: 0, reload: 0,
               ed: {48'd351, 48'd351, 48'd351, 48'd351}};
    tbl[2] = '{name: "T5", im: 0, fm: 0, rmode: 0, inject: 1, reload: 0,
               ed: {48'd351, 48'd351, 48'd351, 48'd351}};
`ifdef CONV_RELU_EN
    tbl[3] = '{name: "T3", im: 1, fm: 1, rmode: 0, inject: 0, reload: 1,
               ed: {48'd0, 48'd0, 48'd0, 48'd0}};
`else
    tbl[3] = '{name: "T3", im: 1, fm: 1, rmode: 0, inject: 0, reload: 1,
               ed: {neg27, neg27, neg27, neg27}};
`endif
    tbl[4] = '{name: "T4", im: 2, fm: 2, rmode: 0, inject: 0, reload: 1,
               ed: {48'd10, 48'd9, 48'd6, 48'd5}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy",  64'(o_busy), 64'd0);
    check("reset done",  64'(o_done), 64'd0);
    check("reset valid", 64'(o_out_valid), 64'd0);
    check("reset last",  64'(o_out_last), 64'd0);
    check("reset data",  64'(o_out_data), 64'd0);
    check("reset row",   64'(o_out_row), 64'd0);
    check("reset col",   64'(o_out_col), 64'd0);

    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        // T6: reset while the first output beat is pending.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_out_ready = 1'b0;
        w = 0;
        while (!o_out_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        check("T6 reached OUT", 64'(o_out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("T6 busy after rst",  64'(o_busy), 64'd0);
        check("T6 valid after rst", 64'(o_out_valid), 64'd0);
        check("T6 done after rst",  64'(o_done), 64'd0);
        check("T6 data after rst",  64'(o_out_data), 64'd0);
        rst = 1'b0;
        flag = 0;
        repeat (40) begin
          @(negedge clk);
          if (o_done || o_out_valid || o_busy) flag = 1;
        end
        check("T6 quiet after abort", 64'(flag), 64'd0);
        run_conv("T6", 0, 1'b0);
        check_beats("T6", tbl[0].ed);
      end
      if (tbl[i].reload) load(tbl[i].im, tbl[i].fm);
      run_conv(tbl[i].name, tbl[i].rmode, tbl[i].inject);
      check_beats(tbl[i].name, tbl[i].ed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
